// File: rtl/lcd_scan_controller.sv
// lcd_scan_controller: SED1565-style command/data bus decoder with a COLS x PAGES
// byte display RAM and a 2-stage pipelined scan-out port for the video path.
module lcd_scan_controller #(
  parameter int          COLS      = 132,
  parameter int          PAGES     = 9,
  parameter logic [23:0] ADDR_CMD  = 24'h20FE,
  parameter logic [23:0] ADDR_DATA = 24'h20FF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_write,
  input  logic        bus_read,
  input  logic [23:0] address_in,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic [5:0]  lcd_contrast,
  output logic        display_on,
  input  logic        scan_req,
  input  logic [7:0]  scan_x,
  input  logic [5:0]  scan_y,
  output logic        scan_valid,
  output logic        scan_pixel
);
  localparam int         DEPTH     = COLS * PAGES;
  localparam int         AW        = $clog2(DEPTH);
  localparam logic [7:0] LAST_COL  = 8'(COLS - 1);
  localparam logic [3:0] LAST_PAGE = 4'(PAGES - 1);

  logic [7:0]    ram [0:DEPTH-1];

  logic          wr_q, rd_q;
  logic          wr_edge, rd_edge, is_cmd, is_data;
  logic [5:0]    contrast;
  logic          contrast_set;
  logic [7:0]    column, rmw_col;
  logic [3:0]    page;
  logic [5:0]    start_line;
  logic          rmw, seg_dir, max_contrast, all_on, invert, row_order;
  logic [7:0]    col_inc, col_map;
  logic          cpu_ok, ram_we, soft_rst;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    rd_buf;

  logic [5:0]    scan_row, scan_line;
  logic [AW-1:0] scan_addr;
  logic          scan_in_range;
  logic          s1_valid, s1_in_range;
  logic [AW-1:0] s1_addr;
  logic [2:0]    s1_bit;
  logic [7:0]    scan_byte;
  logic          scan_pix;

  // Bus decode; a simultaneous read edge is dropped in favour of the write
  always_comb begin
    wr_edge  = bus_write & ~wr_q;
    rd_edge  = bus_read & ~rd_q & ~wr_edge;
    is_cmd   = (address_in == ADDR_CMD);
    is_data  = (address_in == ADDR_DATA);
    col_inc  = (column < LAST_COL) ? column + 8'd1 : LAST_COL;
    col_map  = seg_dir ? LAST_COL - column : column;
    cpu_ok   = (page <= LAST_PAGE) && (column <= LAST_COL);
    cpu_addr = cpu_ok ? AW'(page) * AW'(COLS) + AW'(col_map) : {AW{1'b0}};
    ram_we   = wr_edge & is_data & ~contrast_set & cpu_ok;
    soft_rst = wr_edge & is_cmd & ~contrast_set & (data_in == 8'hE2);
  end

  // Strobe history for rising-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= 1'b0;
      rd_q <= 1'b0;
    end else begin
      wr_q <= bus_write;
      rd_q <= bus_read;
    end
  end

  // Control registers: command decode, contrast entry, column/page tracking
  always_ff @(posedge clk) begin
    if (reset || soft_rst) begin
      contrast     <= 6'h20;
      contrast_set <= 1'b0;
      column       <= 8'd0;
      page         <= 4'd0;
      start_line   <= 6'd0;
      rmw          <= 1'b0;
      rmw_col      <= 8'd0;
      seg_dir      <= 1'b0;
      max_contrast <= 1'b0;
      all_on       <= 1'b0;
      invert       <= 1'b0;
      display_on   <= 1'b0;
      row_order    <= 1'b0;
    end else if (wr_edge && is_cmd) begin
      if (contrast_set) begin
        contrast     <= data_in[5:0];
        contrast_set <= 1'b0;
      end else begin
        casez (data_in)
          8'b0000_????: column       <= {column[7:4], data_in[3:0]};
          8'b0001_????: column       <= {data_in[3:0], column[3:0]};
          8'b01??_????: start_line   <= data_in[5:0];
          8'b1000_0001: contrast_set <= 1'b1;
          8'b1010_000?: seg_dir      <= data_in[0];
          8'b1010_001?: max_contrast <= data_in[0];
          8'b1010_010?: all_on       <= data_in[0];
          8'b1010_011?: invert       <= data_in[0];
          8'b1010_111?: display_on   <= data_in[0];
          8'b1011_????: page         <= data_in[3:0];
          8'b1100_????: row_order    <= data_in[3];
          8'b1110_0000: begin
            rmw     <= 1'b1;
            rmw_col <= column;
          end
          8'b1110_1110: begin
            rmw    <= 1'b0;
            column <= rmw_col;
          end
          default: begin
          end
        endcase
      end
    end else if (wr_edge && is_data) begin
      if (contrast_set) begin
        contrast     <= data_in[5:0];
        contrast_set <= 1'b0;
      end else begin
        column <= col_inc;
      end
    end else if (rd_edge && is_data) begin
      if (!rmw) begin
        column <= col_inc;
      end
    end else if (rd_edge && is_cmd && contrast_set) begin
      contrast     <= 6'h3F;
      contrast_set <= 1'b0;
    end
  end

  // CPU RAM port: write, plus a read buffer refreshed from the current address every cycle
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[cpu_addr] <= data_in;
    end
    rd_buf <= ram[cpu_addr];
  end

  // Read mux and effective contrast
  always_comb begin
    data_out = 8'h00;
    if (contrast_set) begin
      data_out = 8'h00;
    end else if (is_cmd) begin
      data_out = 8'h40 | {2'b00, display_on, 5'b00000};
    end else if (is_data) begin
      if (page < LAST_PAGE) begin
        data_out = rd_buf;
      end else if (page == LAST_PAGE) begin
        data_out = {7'b0000000, rd_buf[0]};
      end else begin
        data_out = 8'h00;
      end
    end else begin
      data_out = 8'h00;
    end
    lcd_contrast = max_contrast ? 6'h3F : contrast;
  end

  // Scan stage 1 address: row order, then start-line wrap in 6 bits
  always_comb begin
    scan_row      = row_order ? 6'd63 - scan_y : scan_y;
    scan_line     = scan_row + start_line;
    scan_in_range = (scan_x <= LAST_COL);
    scan_addr     = scan_in_range ? AW'(scan_line[5:3]) * AW'(COLS) + AW'(scan_x) : {AW{1'b0}};
  end

  // Scan stage 1 register
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_in_range <= 1'b0;
      s1_addr     <= {AW{1'b0}};
      s1_bit      <= 3'd0;
    end else begin
      s1_valid    <= scan_req;
      s1_in_range <= scan_in_range;
      s1_addr     <= scan_addr;
      s1_bit      <= scan_line[2:0];
    end
  end

  // Scan stage 2 pixel; modifiers are taken at this stage
  always_comb begin
    scan_byte = ram[s1_addr];
    if (!s1_in_range) begin
      scan_pix = 1'b0;
    end else if (!display_on) begin
      scan_pix = 1'b0;
    end else if (all_on) begin
      scan_pix = 1'b1;
    end else begin
      scan_pix = scan_byte[s1_bit] ^ invert;
    end
  end

  // Scan stage 2 register
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_valid <= 1'b0;
      scan_pixel <= 1'b0;
    end else begin
      scan_valid <= s1_valid;
      scan_pixel <= s1_valid & scan_pix;
    end
  end
endmodule

// File: tb/tb_lcd_scan_controller.sv
// Directed bench for lcd_scan_controller: bus decode, RAM, RMW, scan pipeline.
module tb_lcd_scan_controller;
  localparam logic [23:0] CMD  = 24'h20FE;
  localparam logic [23:0] DATA = 24'h20FF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bus_write = 1'b0;
  logic        bus_read = 1'b0;
  logic [23:0] address_in = CMD;
  logic [7:0]  data_in = 8'h00;
  logic [7:0]  data_out;
  logic [5:0]  lcd_contrast;
  logic        display_on;
  logic        scan_req = 1'b0;
  logic [7:0]  scan_x = 8'd0;
  logic [5:0]  scan_y = 6'd0;
  logic        scan_valid;
  logic        scan_pixel;

  int tests = 0;
  int failed = 0;

  lcd_scan_controller dut (
    .clk(clk), .reset(reset), .bus_write(bus_write), .bus_read(bus_read),
    .address_in(address_in), .data_in(data_in), .data_out(data_out),
    .lcd_contrast(lcd_contrast), .display_on(display_on), .scan_req(scan_req),
    .scan_x(scan_x), .scan_y(scan_y), .scan_valid(scan_valid), .scan_pixel(scan_pixel)
  );

  always #5 clk = ~clk;

  task automatic bus_wr(input logic [23:0] a, input logic [7:0] d);
    address_in = a; data_in = d; bus_write = 1'b1;
    @(posedge clk); #1;
    bus_write = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic bus_rd(input logic [23:0] a);
    address_in = a; bus_read = 1'b1;
    @(posedge clk); #1;
    bus_read = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic peek(input logic [23:0] a);
    address_in = a;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic set_col(input logic [7:0] c);
    bus_wr(CMD, {4'h1, c[7:4]});
    bus_wr(CMD, {4'h0, c[3:0]});
  endtask

  task automatic do_scan(input logic [7:0] x, input logic [5:0] y,
                         output logic mid_v, output logic v, output logic p);
    scan_x = x; scan_y = y; scan_req = 1'b1;
    @(posedge clk); #1;
    scan_req = 1'b0; mid_v = scan_valid;
    @(posedge clk); #1;
    v = scan_valid; p = scan_pixel;
  endtask

  task automatic test_reset;
    address_in = CMD;
    tests++; if (data_out !== 8'h40) begin failed++; $display("FAIL reset_status: got %h want %h", data_out, 8'h40); end
    tests++; if (lcd_contrast !== 6'h20) begin failed++; $display("FAIL reset_contrast: got %h want %h", lcd_contrast, 6'h20); end
    tests++; if (display_on !== 1'b0) begin failed++; $display("FAIL reset_display_on: got %b want 0", display_on); end
    tests++; if ({scan_valid, scan_pixel} !== 2'b00) begin failed++; $display("FAIL reset_scan: got %b want 00", {scan_valid, scan_pixel}); end
    bus_wr(CMD, 8'hAF);
    tests++; if (data_out !== 8'h60) begin failed++; $display("FAIL status_on: got %h want %h", data_out, 8'h60); end
    tests++; if (display_on !== 1'b1) begin failed++; $display("FAIL display_on: got %b want 1", display_on); end
  endtask

  task automatic test_contrast;
    bus_wr(CMD, 8'h81);
    tests++; if (data_out !== 8'h00) begin failed++; $display("FAIL status_masked: got %h want 00", data_out); end
    bus_wr(CMD, 8'h15);
    tests++; if (lcd_contrast !== 6'h15) begin failed++; $display("FAIL contrast_set: got %h want 15", lcd_contrast); end
    tests++; if (data_out !== 8'h60) begin failed++; $display("FAIL status_after_set: got %h want 60", data_out); end
    bus_wr(CMD, 8'hA3);
    tests++; if (lcd_contrast !== 6'h3F) begin failed++; $display("FAIL max_contrast: got %h want 3f", lcd_contrast); end
    bus_wr(CMD, 8'hA2);
    tests++; if (lcd_contrast !== 6'h15) begin failed++; $display("FAIL max_contrast_off: got %h want 15", lcd_contrast); end
    bus_wr(CMD, 8'h81);
    bus_rd(CMD);
    tests++; if (lcd_contrast !== 6'h3F) begin failed++; $display("FAIL contrast_read: got %h want 3f", lcd_contrast); end
    bus_wr(CMD, 8'h81);
    bus_wr(DATA, 8'h0A);
    tests++; if (lcd_contrast !== 6'h0A) begin failed++; $display("FAIL contrast_data: got %h want 0a", lcd_contrast); end
  endtask

  task automatic test_fill;
    bus_wr(CMD, 8'h10); bus_wr(CMD, 8'h00); bus_wr(CMD, 8'hB0);
    for (int i = 0; i < 140; i++) bus_wr(DATA, 8'hAA);
    bus_wr(DATA, 8'h55);
    peek(DATA);
    tests++; if (data_out !== 8'h55) begin failed++; $display("FAIL col_saturate: got %h want 55", data_out); end
    set_col(8'd130); peek(DATA);
    tests++; if (data_out !== 8'hAA) begin failed++; $display("FAIL fill_col130: got %h want aa", data_out); end
    set_col(8'd0); peek(DATA);
    tests++; if (data_out !== 8'hAA) begin failed++; $display("FAIL fill_col0: got %h want aa", data_out); end
  endtask

  task automatic test_seg_dir;
    bus_wr(CMD, 8'hA1);
    set_col(8'd0);
    bus_wr(DATA, 8'h01);
    peek(DATA);
    tests++; if (data_out !== 8'hAA) begin failed++; $display("FAIL segdir_col1: got %h want aa", data_out); end
    bus_wr(CMD, 8'hA0);
    set_col(8'd131); peek(DATA);
    tests++; if (data_out !== 8'h01) begin failed++; $display("FAIL segdir_map: got %h want 01", data_out); end
    set_col(8'd0); peek(DATA);
    tests++; if (data_out !== 8'hAA) begin failed++; $display("FAIL segdir_col0: got %h want aa", data_out); end
  endtask

  task automatic test_rmw;
    bus_wr(CMD, 8'hB1);
    set_col(8'd5);
    bus_wr(DATA, 8'h11); bus_wr(DATA, 8'h22); bus_wr(DATA, 8'h33);
    set_col(8'd5);
    bus_wr(CMD, 8'hE0);
    for (int i = 0; i < 3; i++) bus_rd(DATA);
    peek(DATA);
    tests++; if (data_out !== 8'h11) begin failed++; $display("FAIL rmw_read_hold: got %h want 11", data_out); end
    bus_wr(DATA, 8'h44); bus_wr(DATA, 8'h55);
    peek(DATA);
    tests++; if (data_out !== 8'h33) begin failed++; $display("FAIL rmw_write_inc: got %h want 33", data_out); end
    bus_wr(CMD, 8'hEE);
    peek(DATA);
    tests++; if (data_out !== 8'h44) begin failed++; $display("FAIL rmw_restore: got %h want 44", data_out); end
    bus_rd(DATA); peek(DATA);
    tests++; if (data_out !== 8'h55) begin failed++; $display("FAIL read_inc: got %h want 55", data_out); end
  endtask

  task automatic test_scan;
    logic mv, v, p;
    bus_wr(CMD, 8'hB0); set_col(8'd3);
    bus_wr(DATA, 8'h01);
    bus_wr(CMD, 8'h7F);
    do_scan(8'd3, 6'd1, mv, v, p);
    tests++; if (mv !== 1'b0) begin failed++; $display("FAIL scan_latency: valid after 1 cycle got %b want 0", mv); end
    tests++; if ({v, p} !== 2'b11) begin failed++; $display("FAIL scan_wrap: got %b want 11", {v, p}); end
    do_scan(8'd3, 6'd2, mv, v, p);
    tests++; if ({v, p} !== 2'b10) begin failed++; $display("FAIL scan_bit1: got %b want 10", {v, p}); end
    do_scan(8'd0, 6'd2, mv, v, p);
    tests++; if ({v, p} !== 2'b11) begin failed++; $display("FAIL scan_col0: got %b want 11", {v, p}); end
    bus_wr(CMD, 8'hA7);
    do_scan(8'd3, 6'd1, mv, v, p);
    tests++; if ({v, p} !== 2'b10) begin failed++; $display("FAIL scan_invert: got %b want 10", {v, p}); end
    bus_wr(CMD, 8'hA6); bus_wr(CMD, 8'hA5);
    do_scan(8'd3, 6'd2, mv, v, p);
    tests++; if ({v, p} !== 2'b11) begin failed++; $display("FAIL scan_all_on: got %b want 11", {v, p}); end
    do_scan(8'd132, 6'd1, mv, v, p);
    tests++; if ({v, p} !== 2'b10) begin failed++; $display("FAIL scan_oob: got %b want 10", {v, p}); end
    bus_wr(CMD, 8'hA4); bus_wr(CMD, 8'hC8);
    do_scan(8'd3, 6'd62, mv, v, p);
    tests++; if ({v, p} !== 2'b11) begin failed++; $display("FAIL scan_row_order: got %b want 11", {v, p}); end
    bus_wr(CMD, 8'hC0); bus_wr(CMD, 8'hAE);
    do_scan(8'd3, 6'd1, mv, v, p);
    tests++; if ({v, p} !== 2'b10) begin failed++; $display("FAIL scan_display_off: got %b want 10", {v, p}); end
    bus_wr(CMD, 8'hAF);
  endtask

  task automatic test_back_to_back;
    scan_x = 8'd3; scan_y = 6'd1; scan_req = 1'b1;
    @(posedge clk); #1;
    scan_y = 6'd2;
    @(posedge clk); #1;
    scan_req = 1'b0;
    tests++; if ({scan_valid, scan_pixel} !== 2'b11) begin failed++; $display("FAIL b2b_first: got %b want 11", {scan_valid, scan_pixel}); end
    @(posedge clk); #1;
    tests++; if ({scan_valid, scan_pixel} !== 2'b10) begin failed++; $display("FAIL b2b_second: got %b want 10", {scan_valid, scan_pixel}); end
    @(posedge clk); #1;
    tests++; if (scan_valid !== 1'b0) begin failed++; $display("FAIL b2b_drain: got %b want 0", scan_valid); end
  endtask

  task automatic test_page8;
    bus_wr(CMD, 8'hB8); set_col(8'd0);
    bus_wr(DATA, 8'hFF);
    set_col(8'd0); peek(DATA);
    tests++; if (data_out !== 8'h01) begin failed++; $display("FAIL page8_mask: got %h want 01", data_out); end
    bus_wr(CMD, 8'hB9); set_col(8'd0);
    bus_wr(DATA, 8'h76);
    peek(DATA);
    tests++; if (data_out !== 8'h00) begin failed++; $display("FAIL page9_read: got %h want 00", data_out); end
    bus_wr(CMD, 8'hB8); set_col(8'd0); peek(DATA);
    tests++; if (data_out !== 8'h01) begin failed++; $display("FAIL page9_discard: got %h want 01", data_out); end
  endtask

  task automatic test_simultaneous;
    bus_wr(CMD, 8'hB2); set_col(8'd0);
    bus_wr(DATA, 8'h12); bus_wr(DATA, 8'h34);
    set_col(8'd0);
    address_in = DATA; data_in = 8'h99; bus_write = 1'b1; bus_read = 1'b1;
    @(posedge clk); #1;
    bus_write = 1'b0; bus_read = 1'b0;
    @(posedge clk); #1;
    peek(DATA);
    tests++; if (data_out !== 8'h34) begin failed++; $display("FAIL sim_column: got %h want 34", data_out); end
    set_col(8'd0); peek(DATA);
    tests++; if (data_out !== 8'h99) begin failed++; $display("FAIL sim_write: got %h want 99", data_out); end
    bus_wr(CMD, 8'h81);
    address_in = CMD; data_in = 8'h07; bus_write = 1'b1; bus_read = 1'b1;
    @(posedge clk); #1;
    bus_write = 1'b0; bus_read = 1'b0;
    @(posedge clk); #1;
    tests++; if (lcd_contrast !== 6'h07) begin failed++; $display("FAIL sim_read_dropped: got %h want 07", lcd_contrast); end
  endtask

  task automatic test_soft_reset;
    bus_wr(CMD, 8'hE2);
    tests++; if (lcd_contrast !== 6'h20) begin failed++; $display("FAIL soft_reset_contrast: got %h want 20", lcd_contrast); end
    tests++; if (data_out !== 8'h40) begin failed++; $display("FAIL soft_reset_status: got %h want 40", data_out); end
  endtask

  task automatic test_reset_midscan;
    bus_wr(CMD, 8'hAF);
    scan_x = 8'd3; scan_y = 6'd1; scan_req = 1'b1;
    @(posedge clk); #1;
    scan_req = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    tests++; if (scan_valid !== 1'b0) begin failed++; $display("FAIL midscan_reset: got %b want 0", scan_valid); end
    reset = 1'b0;
    @(posedge clk); #1;
    tests++; if (scan_valid !== 1'b0) begin failed++; $display("FAIL midscan_stage1: got %b want 0", scan_valid); end
    tests++; if (display_on !== 1'b0) begin failed++; $display("FAIL midscan_display: got %b want 0", display_on); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_contrast();
    test_fill();
    test_seg_dir();
    test_rmw();
    test_scan();
    test_back_to_back();
    test_page8();
    test_simultaneous();
    test_soft_reset();
    test_reset_midscan();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/lcd_scan_controller.md
# lcd_scan_controller

Parametrised successor to the Pokémon Mini SED1565-style LCD controller. It decodes the command and data registers on the CPU bus and holds a COLS x PAGES byte display RAM. Added over the previous generation: a read-modify-write column restore, honoured pixel modifiers, and a pipelined scan-out port. The video path uses the scan-out port to fetch start-line-wrapped, row-ordered, modifier-applied pixels independently of CPU access.

## Interface
- COLS, 132: columns per page; column counter saturates at COLS-1.
- PAGES, 9: pages 0..PAGES-2 are 8 px high; page PAGES-1 is 1 px high (bit 0 only).
- ADDR_CMD, 24'h20FE: command/status register address.
- ADDR_DATA, 24'h20FF: display data register address.
- clk  in  1  clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- bus_write  in  1  write strobe; acted on at rising edge only (one access per assertion).
- bus_read  in  1  read strobe; acted on at rising edge only.
- address_in  in  24  bus address.
- data_in  in  8  write data.
- data_out  out  8  combinational read data.
- lcd_contrast  out  6  effective contrast.
- display_on  out  1  display-enable flag.
- scan_req  in  1  scan fetch request, one per cycle allowed.
- scan_x  in  8  scan column 0..COLS-1.
- scan_y  in  6  scan row 0..63 as displayed.
- scan_valid  out  1  scan result valid.
- scan_pixel  out  1  scan result pixel.

## Operation
- Edge detect: wr_edge = bus_write & !wr_q; rd_edge = bus_read & !rd_q. If both rise in the same cycle, the write is serviced and the read is dropped.
- Command write (ADDR_CMD) while contrast_set=1: contrast <= data_in[5:0]; contrast_set <= 0.
- Command decode otherwise:
  - 0000_xxxx / 0001_xxxx: set column low/high nibble.
  - 01xx_xxxx: start_line.
  - 1000_0001: contrast_set <= 1.
  - 1010_000d: seg_dir.
  - 1010_001d: max_contrast.
  - 1010_010d: all_on.
  - 1010_011d: invert.
  - 1010_111d: display_on.
  - 1011_pppp: page.
  - 1100_rxxx: row_order <= r.
  - 1110_0000: rmw <= 1; rmw_col <= column.
  - 1110_1110: rmw <= 0; column <= rmw_col.
  - 1110_0010: soft reset; same values as hardware reset.
  - Other codes: ignored.
- Column nibble writes are honoured in RMW mode; the 1110_1110 restore overrides them.
- Data write (ADDR_DATA) with contrast_set=1: loads contrast and clears the flag; RAM is untouched.
- Data write otherwise: RAM[page*COLS + (seg_dir ? COLS-1-column : column)] <= data_in, then column++ saturating at COLS-1. Writes with page >= PAGES are discarded, but column still increments.
- Data read edge: column++ (saturating) only when rmw=0. Command read edge with contrast_set=1 sets contrast to 6'h3F and clears the flag.
- data_out:
  - 0 whenever contrast_set=1.
  - ADDR_CMD: 8'h40 | display_on<<5.
  - ADDR_DATA: rd_buf, masked to bit 0 on page PAGES-1, 0 for page >= PAGES.
  - Any other address: 0.
- lcd_contrast = max_contrast ? 6'h3F : contrast.
- Scan path:
  - Row: ry = row_order ? 63-scan_y : scan_y; line = (ry + start_line) mod 64 (6-bit wrap).
  - RAM fetch: page line[5:3], bit line[2:0], column scan_x.
  - Pixel: p = !display_on ? 0 : all_on ? 1 : bit ^ invert.
  - Out-of-range scan_x >= COLS yields p=0.
- RAM: true dual-port. CPU port is read/write; scan port is read-only. A same-cycle write and scan read to one address returns the old data on the scan port.
- Reset values:
  - contrast 6'h20, column 0, page 0, start_line 0, rmw_col 0.
  - All mode flags 0, contrast_set 0, wr_q/rd_q 0.
  - scan_valid 0, scan_pixel 0, display_on 0, lcd_contrast 6'h20.
  - RAM contents are not reset.

## Timing
- Register and RAM updates land on the clock edge following the strobe rising edge.
- rd_buf reloads every cycle from the current CPU address. data_out reflects a new column/page 1 cycle after it changes, i.e. the byte at the pre-increment column remains visible on the cycle of the read edge.
- Scan latency is 2 cycles, fully pipelined. Stage 1 registers the address, stage 2 registers RAM data plus modifiers. scan_valid = scan_req delayed by 2.
- Modifier flags are sampled in stage 2.
- Reset mid-scan clears both pipeline valids the same cycle.

## Test plan
- Reset, then read ADDR_CMD -> data_out=8'h40, lcd_contrast=6'h20. Write 0xAF, read again -> 8'h60, display_on=1.
- Write 0x81 then 0x15 to ADDR_CMD -> lcd_contrast=6'h15. Write 0xA3 -> lcd_contrast=6'h3F.
- Write 0x10,0x00,0xB0, then write 0xAA x140 to ADDR_DATA -> RAM cols 0..131 of page 0 =0xAA, column saturates at 131. With 0xA1 set, column 0 maps to RAM offset 131.
- RMW: column=5. Sequence 0xE0, read ADDR_DATA x3, write x2, 0xEE. Required: column stays 5 across the reads, reaches 7 after the writes, and is restored to 5 after 0xEE.
- Page 0 byte 0x01 at col 3, start_line=63 (0x7F), scan_req x=3,y=1 -> scan_valid 2 cycles later with pixel=1. With 0xA7 set -> pixel 0. With 0xA5 set -> pixel 1. With display off -> pixel 0.
- Page 8: write 0xFF at col 0, read it back -> data_out=8'h01. Write with page=9 -> RAM unchanged, data_out=0. Simultaneous bus_write/bus_read rising -> only the write takes effect.
